// File: rtl/mbx_ombx_reader.sv
// Outbound mailbox reader: fetches the object from SRAM one DWORD at a time and hands each word to the system.
// Build option MBX_OMBX_RERR_EN: an SRAM read error aborts the read and pulses rd_err_o.
module mbx_ombx_reader #(
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32,
  parameter int unsigned SizeW = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mbx_read_i,
  input  logic             clear_i,
  input  logic [AddrW-1:0] base_i,
  input  logic [AddrW-1:0] limit_i,
  input  logic [SizeW-1:0] size_i,
  output logic             sram_req_o,
  output logic [AddrW-1:0] sram_addr_o,
  input  logic             sram_gnt_i,
  input  logic             sram_rvalid_i,
  input  logic [DataW-1:0] sram_rdata_i,
  input  logic             sram_rerror_i,
  input  logic             sys_pop_i,
  output logic [DataW-1:0] rdata_o,
  output logic             rdata_valid_o,
  output logic             sys_read_all_o,
  output logic             rd_err_o
);

  // Handshakes: sram_req_o/sram_addr_o stay asserted and stable until the cycle
  // sram_gnt_i is seen (never withdrawn); exactly one sram_rvalid_i follows each grant.
  // rdata_o is valid while rdata_valid_o is high; a sys_pop_i in that window consumes it.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    HOLD     = 3'd3,
    FLUSH    = 3'd4
  } state_e;

  state_e           state_q;
  logic             mbx_read_q;
  logic [SizeW-1:0] size_q;
  logic [SizeW-1:0] cnt_q;
  logic [AddrW-1:0] addr_q;
  logic             flush_gnt_q;
  logic             abort;
  logic             last_word;
  logic             rsp_err;

  assign abort     = clear_i | ~mbx_read_i;
  assign last_word = (cnt_q == size_q);

`ifdef MBX_OMBX_RERR_EN
  assign rsp_err = sram_rerror_i;
`else
  logic unused_rerror;
  assign unused_rerror = sram_rerror_i;
  assign rsp_err       = 1'b0;
`endif

  // Combinational so the completion pulse lines up with the consuming pop.
  assign sys_read_all_o = (state_q == HOLD) & sys_pop_i & last_word & ~abort;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      mbx_read_q    <= 1'b0;
      size_q        <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      flush_gnt_q   <= 1'b0;
      sram_req_o    <= 1'b0;
      sram_addr_o   <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      rd_err_o      <= 1'b0;
    end else begin
      mbx_read_q <= mbx_read_i;
      rd_err_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mbx_read_i && !mbx_read_q && !clear_i) begin
            size_q <= size_i;
            cnt_q  <= '0;
            addr_q <= base_i;
            if (size_i == '0) begin
              rdata_o       <= '0;
              rdata_valid_o <= 1'b1;
              state_q       <= HOLD;
            end else if (base_i > limit_i) begin
              rd_err_o <= 1'b1;
            end else begin
              sram_req_o  <= 1'b1;
              sram_addr_o <= base_i;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          if (sram_gnt_i) begin
            sram_req_o  <= 1'b0;
            flush_gnt_q <= 1'b1;
            state_q     <= abort ? FLUSH : WAIT_RSP;
          end else if (abort) begin
            flush_gnt_q <= 1'b0;
            state_q     <= FLUSH;
          end
        end
        WAIT_RSP: begin
          if (abort) begin
            // A response arriving in the abort cycle is the one being flushed.
            flush_gnt_q <= 1'b1;
            state_q     <= sram_rvalid_i ? IDLE : FLUSH;
          end else if (sram_rvalid_i) begin
            if (rsp_err) begin
              rd_err_o      <= 1'b1;
              rdata_o       <= '0;
              rdata_valid_o <= 1'b0;
              state_q       <= IDLE;
            end else begin
              rdata_o       <= sram_rdata_i;
              rdata_valid_o <= 1'b1;
              cnt_q         <= cnt_q + SizeW'(1);
              addr_q        <= addr_q + AddrW'(4);
              state_q       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (abort) begin
            rdata_valid_o <= 1'b0;
            state_q       <= IDLE;
          end else if (sys_pop_i) begin
            rdata_valid_o <= 1'b0;
            if (last_word) begin
              state_q <= IDLE;
            end else if (addr_q > limit_i) begin
              rd_err_o <= 1'b1;
              state_q  <= IDLE;
            end else begin
              sram_req_o  <= 1'b1;
              sram_addr_o <= addr_q;
              state_q     <= REQ;
            end
          end
        end
        FLUSH: begin
          if (!flush_gnt_q) begin
            if (sram_gnt_i) begin
              sram_req_o  <= 1'b0;
              flush_gnt_q <= 1'b1;
            end
          end else if (sram_rvalid_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
